regfile_write_ctrl: RTL

//   Shares the single register-file write port between two writeback requesters: ALU result and memory load.
//   Two-way round-robin arbitration; the winner's write is registered onto the register-file write port.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/regfile_write_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and writeback requester IDs
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 4;

    // Requester IDs double as bit positions in the arbiter req/gnt vectors
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with combinational grant
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e last_grant_q;
    req_id_e last_grant_d;

    // Grant the lone requester, or on conflict the one that did not win last; nothing while in reset
    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (rst_n) begin
            gnt[REQ_ALU] = req[REQ_ALU] & (~req[REQ_MEM] | (last_grant_q == REQ_MEM));
            gnt[REQ_MEM] = req[REQ_MEM] & (~req[REQ_ALU] | (last_grant_q == REQ_ALU));
        end
        if (gnt[REQ_ALU]) begin
            last_grant_d = REQ_ALU;
        end else if (gnt[REQ_MEM]) begin
            last_grant_d = REQ_MEM;
        end
    end

    // Remember the most recent winner; reset favours the ALU on the first conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// rtl/regfile_write_ctrl.sv - register-file write port sharing and busy scoreboard
module regfile_write_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_req,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_gnt,
    input  logic                mem_req,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_gnt,
    output logic                rf_write_en,
    output logic [ADDR_W-1:0]   rf_write_addr,
    output logic [DATA_W-1:0]   rf_write_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   chk_addr1,
    input  logic [ADDR_W-1:0]   chk_addr2,
    output logic                chk_busy1,
    output logic                chk_busy2,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                rsv_err
);

    import cpu_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS);

    // Physical register index: upper address bits alias onto the low registers
    function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(32'(a) % 32'(NUM_REGS));
    endfunction

    logic [1:0]          gnt;
    logic                rf_write_en_q,   rf_write_en_d;
    logic [ADDR_W-1:0]   rf_write_addr_q, rf_write_addr_d;
    logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
    logic [NUM_REGS-1:0] busy_q,          busy_d;
    logic                rsv_err_q,       rsv_err_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({mem_req, alu_req}),
        .gnt   (gnt)
    );

    assign alu_gnt = gnt[REQ_ALU];
    assign mem_gnt = gnt[REQ_MEM];

    // Winner's write goes to the register-file port; addr/data hold when idle
    always_comb begin
        rf_write_en_d   = alu_gnt | mem_gnt;
        rf_write_addr_d = rf_write_addr_q;
        rf_write_data_d = rf_write_data_q;
        if (alu_gnt) begin
            rf_write_addr_d = alu_addr;
            rf_write_data_d = alu_data;
        end else if (mem_gnt) begin
            rf_write_addr_d = mem_addr;
            rf_write_data_d = mem_data;
        end
    end

    // Scoreboard: clear on the write the register file performs this edge, then set on reservation
    always_comb begin
        busy_d    = busy_q;
        rsv_err_d = rsv_err_q;
        if (rf_write_en_q) begin
            busy_d[reg_idx(rf_write_addr_q)] = 1'b0;
        end
        if (rsv_en) begin
            // A register being retired this very edge is free for a new reservation
            if (busy_q[reg_idx(rsv_addr)] && !busy_d[reg_idx(rsv_addr)] == 1'b0) begin
                rsv_err_d = 1'b1;
            end
            busy_d[reg_idx(rsv_addr)] = 1'b1;
        end
    end

    // Write-port register stage and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en_q   <= 1'b0;
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
            busy_q          <= '0;
            rsv_err_q       <= 1'b0;
        end else begin
            rf_write_en_q   <= rf_write_en_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
            busy_q          <= busy_d;
            rsv_err_q       <= rsv_err_d;
        end
    end

    assign rf_write_en   = rf_write_en_q;
    assign rf_write_addr = rf_write_addr_q;
    assign rf_write_data = rf_write_data_q;
    assign busy_mask     = busy_q;
    assign rsv_err       = rsv_err_q;
    assign chk_busy1     = busy_q[reg_idx(chk_addr1)];
    assign chk_busy2     = busy_q[reg_idx(chk_addr2)];

endmodule
